// File: rtl/gsim_mem_fetch.sv
// GSIM matrix-memory fetch front end: credit-limited linear reads into a FWFT return FIFO.
// Optional stall statistics port o_stall_cnt is enabled by defining GSIM_FETCH_STATS_EN.
module gsim_mem_fetch #(
  parameter int unsigned WORDS_PER_MATRIX = 17,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [4:0]   i_matrix_num,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic         o_mem_rreq,
  output logic [9:0]   o_mem_addr,
  input  logic         i_mem_rrdy,
  input  logic [255:0] i_mem_dout,
  input  logic         i_mem_dout_vld,
  output logic         o_word_vld,
  output logic [255:0] o_word,
  output logic [4:0]   o_word_mat,
  output logic [4:0]   o_word_row,
  output logic         o_word_last,
  input  logic         i_word_rdy
`ifdef GSIM_FETCH_STATS_EN
  ,
  output logic [15:0]  o_stall_cnt
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DepthV = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [9:0]      total_q, issued_q, delivered_q, total_new;
  logic [CW-1:0]   outstanding_q, fifo_count_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [255:0]    fifo_mem [FIFO_DEPTH];
  logic [4:0]      mat_q, row_q;
  logic            err_q;
  logic            start_acc, req_acc, ret_vld, rd_en;

  assign total_new = 10'(i_matrix_num) * 10'(WORDS_PER_MATRIX);
  assign start_acc = (state_q == StIdle) && i_start;

  // Request depends only on registered state; in-flight plus buffered words never exceed depth.
  assign o_mem_rreq = (state_q == StFetch) && (issued_q < total_q) &&
                      (({1'b0, fifo_count_q} + {1'b0, outstanding_q}) < DepthV);
  assign o_mem_addr = issued_q;
  assign req_acc    = o_mem_rreq && i_mem_rrdy;
  assign ret_vld    = i_mem_dout_vld && (outstanding_q != '0);

  assign o_word_vld  = (fifo_count_q != '0);
  assign rd_en       = o_word_vld && i_word_rdy;
  assign o_word      = o_word_vld ? fifo_mem[rd_ptr_q] : '0;
  assign o_word_mat  = mat_q;
  assign o_word_row  = row_q;
  assign o_word_last = o_word_vld && (delivered_q == total_q - 10'd1);

  assign o_busy = (state_q == StFetch) || (state_q == StDrain);
  assign o_done = (state_q == StDone);
  assign o_err  = err_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_start) state_d = (total_new == '0) ? StDone : StFetch;
      StFetch: if (issued_q == total_q) state_d = StDrain;
      StDrain: if ((outstanding_q == '0) && ((delivered_q + 10'(rd_en)) == total_q)) begin
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= StIdle;
      total_q       <= '0;
      issued_q      <= '0;
      delivered_q   <= '0;
      outstanding_q <= '0;
      fifo_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mat_q         <= '0;
      row_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (i_mem_dout_vld && (outstanding_q == '0)) err_q <= 1'b1;
      if (start_acc) begin
        total_q       <= total_new;
        issued_q      <= '0;
        delivered_q   <= '0;
        outstanding_q <= '0;
        fifo_count_q  <= '0;
        wr_ptr_q      <= '0;
        rd_ptr_q      <= '0;
        mat_q         <= '0;
        row_q         <= '0;
      end else begin
        if (req_acc) issued_q <= issued_q + 10'd1;
        case ({req_acc, ret_vld})
          2'b10:   outstanding_q <= outstanding_q + CW'(1);
          2'b01:   outstanding_q <= outstanding_q - CW'(1);
          default: ;
        endcase
        case ({ret_vld, rd_en})
          2'b10:   fifo_count_q <= fifo_count_q + CW'(1);
          2'b01:   fifo_count_q <= fifo_count_q - CW'(1);
          default: ;
        endcase
        if (ret_vld) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (rd_en) begin
          rd_ptr_q    <= rd_ptr_q + PW'(1);
          delivered_q <= delivered_q + 10'd1;
          if (row_q == 5'(WORDS_PER_MATRIX - 1)) begin
            row_q <= '0;
            mat_q <= mat_q + 5'd1;
          end else begin
            row_q <= row_q + 5'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (ret_vld) fifo_mem[wr_ptr_q] <= i_mem_dout;
  end

`ifdef GSIM_FETCH_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || start_acc) begin
      stall_q <= '0;
    end else if (o_mem_rreq && !i_mem_rrdy && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_gsim_mem_fetch.sv
// Directed bench for gsim_mem_fetch: in-order memory model with configurable latency and
// ready patterns, checking issue order, credit limit, delivered words/tags and completion.
module tb_gsim_mem_fetch;

  localparam int WPM   = 17;
  localparam int DEPTH = 4;

  logic         i_clk = 1'b0;
  logic         i_reset, i_start, i_mem_rrdy, i_mem_dout_vld, i_word_rdy;
  logic [4:0]   i_matrix_num;
  logic [255:0] i_mem_dout;
  logic         o_busy, o_done, o_err, o_mem_rreq, o_word_vld, o_word_last;
  logic [9:0]   o_mem_addr;
  logic [255:0] o_word;
  logic [4:0]   o_word_mat, o_word_row;
`ifdef GSIM_FETCH_STATS_EN
  logic [15:0]  o_stall_cnt;
`endif

  gsim_mem_fetch #(.WORDS_PER_MATRIX(WPM), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_matrix_num   (i_matrix_num),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err),
    .o_mem_rreq     (o_mem_rreq),
    .o_mem_addr     (o_mem_addr),
    .i_mem_rrdy     (i_mem_rrdy),
    .i_mem_dout     (i_mem_dout),
    .i_mem_dout_vld (i_mem_dout_vld),
    .o_word_vld     (o_word_vld),
    .o_word         (o_word),
    .o_word_mat     (o_word_mat),
    .o_word_row     (o_word_row),
    .o_word_last    (o_word_last),
    .i_word_rdy     (i_word_rdy)
`ifdef GSIM_FETCH_STATS_EN
    ,
    .o_stall_cnt    (o_stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] mem_data(input int a);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ (32'(a) * 32'h0000_9E37);
    return {w, ~w, w, ~w, w, ~w, w, 32'(a)};
  endfunction

  int cyc = 0, run_cyc = 0, start_cyc = 0, last_acc_cyc = 0, last_del_cyc = 0;
  int total = 0, issued = 0, delivered = 0, returned = 0;
  int done_cnt = 0, stall_cnt = 0, rreq_cnt = 0;
  int pend_addr[$];
  int pend_due[$];
  int lat_mode = 0, rrdy_mode = 0, bp_start = 0, bp_end = 0;
  bit burst_chk = 0, prev_stall = 0, do_start = 0, first_rreq = 0, full_seen = 0;
  logic [9:0] prev_addr = '0;

  // One cycle: drive inputs at negedge, then record what the next posedge will accept.
  task automatic step();
    int sum;
    @(negedge i_clk);
    cyc++;
    run_cyc++;
    sum = pend_addr.size() + (returned - delivered);
    check("credit_le_depth", 256'(sum <= DEPTH), 256'(1));
    if (sum == DEPTH) begin
      full_seen = 1;
      check("rreq_off_at_full", 256'(o_mem_rreq), 256'(0));
    end
    if (prev_stall) begin
      check("rreq_held", 256'(o_mem_rreq), 256'(1));
      check("addr_held", 256'(o_mem_addr), 256'(prev_addr));
    end
    i_start    = do_start;
    do_start   = 0;
    i_mem_rrdy = (rrdy_mode == 0) ? 1'b1 : ((cyc % 8) < 4);
    i_word_rdy = !(run_cyc >= bp_start && run_cyc < bp_end);
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      i_mem_dout_vld = 1'b1;
      i_mem_dout     = mem_data(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
      returned++;
    end else begin
      i_mem_dout_vld = 1'b0;
      i_mem_dout     = {8{32'hDEAD_BEEF}};
    end
    if (o_done) begin
      done_cnt++;
      if (total > 0) check("done_latency", 256'(cyc - last_del_cyc), 256'(1));
    end
    if (o_mem_rreq) begin
      rreq_cnt++;
      if (!first_rreq) begin
        first_rreq = 1;
        check("first_req_latency", 256'(cyc - start_cyc), 256'(1));
        check("first_req_addr", 256'(o_mem_addr), 256'(0));
      end
    end
    prev_stall = o_mem_rreq && !i_mem_rrdy;
    prev_addr  = o_mem_addr;
    if (prev_stall) stall_cnt++;
    if (o_mem_rreq && i_mem_rrdy) begin
      check("req_addr", 256'(o_mem_addr), 256'(issued));
      if (burst_chk && issued > 0) check("req_back_to_back", 256'(cyc - last_acc_cyc), 256'(1));
      last_acc_cyc = cyc;
      pend_addr.push_back(int'(o_mem_addr));
      pend_due.push_back(cyc + ((lat_mode == 0) ? 1 : 1 + (issued % 3)));
      issued++;
    end
    if (o_word_vld && i_word_rdy) begin
      check("word_data", o_word, mem_data(delivered));
      check("word_mat", 256'(o_word_mat), 256'(delivered / WPM));
      check("word_row", 256'(o_word_row), 256'(delivered % WPM));
      check("word_last", 256'(o_word_last), 256'(delivered == total - 1));
      last_del_cyc = cyc;
      delivered++;
    end
  endtask

  task automatic run(input int num, input int max_cyc, input int abort_at);
    total = num * WPM;
    issued = 0; delivered = 0; returned = 0; done_cnt = 0; stall_cnt = 0; rreq_cnt = 0;
    run_cyc = 0; prev_stall = 0; first_rreq = (num == 0); full_seen = 0;
    i_matrix_num = 5'(num);
    do_start = 1;
    step();
    start_cyc = cyc;
    for (int i = 0; i < max_cyc; i++) begin
      if (done_cnt != 0 || (abort_at > 0 && delivered >= abort_at)) break;
      step();
    end
    if (abort_at > 0) return;
    check("done_seen", 256'(done_cnt), 256'(1));
    check("busy_low_in_done", 256'(o_busy), 256'(0));
    step();
    check("done_once", 256'(done_cnt), 256'(1));
    check("idle_after_done", 256'(o_busy | o_done), 256'(0));
    check("words_delivered", 256'(delivered), 256'(total));
    check("reqs_issued", 256'(issued), 256'(total));
    check("no_err", 256'(o_err), 256'(0));
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_matrix_num = '0; i_mem_rrdy = 1'b0;
    i_mem_dout = '0; i_mem_dout_vld = 1'b0; i_word_rdy = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_busy", 256'(o_busy), 256'(0));
    check("rst_done", 256'(o_done), 256'(0));
    check("rst_err", 256'(o_err), 256'(0));
    check("rst_rreq", 256'(o_mem_rreq), 256'(0));
    check("rst_addr", 256'(o_mem_addr), 256'(0));
    check("rst_word_vld", 256'(o_word_vld), 256'(0));
    check("rst_word", o_word, 256'(0));
    check("rst_mat", 256'(o_word_mat), 256'(0));
    check("rst_row", 256'(o_word_row), 256'(0));
    check("rst_last", 256'(o_word_last), 256'(0));
    i_reset = 1'b0;

    // Zero matrices: done right after start, never a request.
    run(0, 10, 0);
    check("zero_no_rreq", 256'(rreq_cnt), 256'(0));

    // Single matrix, ideal memory and core.
    burst_chk = 1; lat_mode = 0; rrdy_mode = 0;
    run(1, 100, 0);
    burst_chk = 0;

    // Memory-ready throttling over the full 31 matrices.
    lat_mode = 1; rrdy_mode = 1;
    run(31, 5000, 0);
    check("throttle_stalls_seen", 256'(stall_cnt > 0), 256'(1));
`ifdef GSIM_FETCH_STATS_EN
    check("stall_cnt", 256'(o_stall_cnt), 256'(stall_cnt));
`endif

    // Core backpressure for 20 cycles.
    rrdy_mode = 0; bp_start = 5; bp_end = 25;
    run(2, 500, 0);
    check("bp_full_reached", 256'(full_seen), 256'(1));
    bp_start = 0; bp_end = 0;

    // Reset in the middle of a run, then a fresh short run.
    run(8, 2000, 50);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("midrst_busy", 256'(o_busy), 256'(0));
    check("midrst_word_vld", 256'(o_word_vld), 256'(0));
    check("midrst_rreq", 256'(o_mem_rreq), 256'(0));
    i_reset = 1'b0;
    i_mem_dout_vld = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    run(2, 500, 0);

    // Spurious return while idle.
    @(negedge i_clk);
    i_mem_dout_vld = 1'b1;
    i_mem_dout = {8{32'h1234_5678}};
    @(negedge i_clk);
    i_mem_dout_vld = 1'b0;
    check("spur_err", 256'(o_err), 256'(1));
    check("spur_fifo_empty", 256'(o_word_vld), 256'(0));
    repeat (3) @(negedge i_clk);
    check("spur_err_sticky", 256'(o_err), 256'(1));
    check("spur_still_empty", 256'(o_word_vld), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
